// File: rtl/stream_select_mux_pkg.sv
// Shared definitions for the stream select multiplexer family:
// mode encoding, default geometry and a width helper.
package stream_select_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int unsigned DEFAULT_WIDTH  = 8;
    localparam int unsigned DEFAULT_NUM_IN = 8;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_select_mux_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping modulo N.
module rr_priority_pick
    import stream_select_mux_pkg::*;
#(
    parameter int unsigned N     = DEFAULT_NUM_IN,
    parameter int unsigned IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             found_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W:0] ptr_ext;
    logic [IDX_W:0] off;
    logic [IDX_W:0] sum;

    always_comb begin
        ptr_ext = {1'b0, ptr_i};
        dbl     = {req_i, req_i};
        // rotate so bit 0 is the requester at the pointer position
        rot     = N'(dbl >> ptr_ext);
        found_o = 1'b0;
        off     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found_o && rot[i[IDX_W-1:0]]) begin
                found_o = 1'b1;
                off     = (IDX_W+1)'(i);
            end
        end
        sum = ptr_ext + off;
        if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
        grant_o = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/stream_select_mux.sv
// N-channel valid/ready stream mux with registered output, fixed or round-robin.
// Optional OUT_PAR port enabled by STREAM_SELECT_MUX_PARITY_EN.
module stream_select_mux
    import stream_select_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned NUM_IN = DEFAULT_NUM_IN,
    parameter int unsigned SEL_W  = clog2(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_IN*WIDTH-1:0] IN_DATA,
    input  logic [NUM_IN-1:0]       IN_VALID,
    output logic [NUM_IN-1:0]       IN_READY,
    input  logic                    MODE,
    input  logic [SEL_W-1:0]        SELECT,
    output logic [WIDTH-1:0]        OUT,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [SEL_W-1:0]        OUT_SEL
`ifdef STREAM_SELECT_MUX_PARITY_EN
    ,
    output logic                    OUT_PAR
`endif
);

    logic [WIDTH-1:0]  out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              out_par_q, out_par_d;

    logic              ld;
    logic              mode_rr;
    logic              fix_found;
    logic              rr_found;
    logic [SEL_W-1:0]  rr_grant;
    logic              found;
    logic [SEL_W-1:0]  grant;
    logic              xfer;
    logic [WIDTH-1:0]  data_sel;
    logic [NUM_IN-1:0] in_ready_c;

    rr_priority_pick #(
        .N     (NUM_IN),
        .IDX_W (SEL_W)
    ) u_pick (
        .req_i   (IN_VALID),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant),
        .found_o (rr_found)
    );

    always_comb begin
        ld      = ~out_valid_q | OUT_READY;
        mode_rr = (mode_e'(MODE) == MODE_RR);

        // fixed mode looks only at the selected channel's valid
        fix_found = 1'b0;
        if ({1'b0, SELECT} < (SEL_W+1)'(NUM_IN)) fix_found = IN_VALID[SELECT];

        grant = mode_rr ? rr_grant : SELECT;
        found = mode_rr ? rr_found : fix_found;
        xfer  = found & ld;

        data_sel   = '0;
        in_ready_c = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (k[SEL_W-1:0] == grant) begin
                data_sel                 = IN_DATA[k*WIDTH +: WIDTH];
                in_ready_c[k[SEL_W-1:0]] = xfer;
            end
        end
        IN_READY = RESET ? '0 : in_ready_c;

        out_d       = out_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        out_par_d   = out_par_q;
        ptr_d       = ptr_q;
        if (ld) begin
            out_valid_d = found;
            if (found) begin
                out_d     = data_sel;
                out_sel_d = grant;
                out_par_d = ^data_sel;
                if (mode_rr) begin
                    ptr_d = (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            out_par_q   <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_par_q   <= out_par_d;
            ptr_q       <= ptr_d;
        end
    end

    assign OUT       = out_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_SEL   = out_sel_q;
`ifdef STREAM_SELECT_MUX_PARITY_EN
    assign OUT_PAR   = out_par_q;
`else
    logic unused_par;
    assign unused_par = out_par_q;
`endif

endmodule

// File: tb/tb_stream_select_mux.sv
// Randomized and directed checks of stream_select_mux against a queue-free
// behavioural model of the grant/hold rules.
module tb_stream_select_mux;

    localparam int N = 8;
    localparam int W = 8;

    logic           CLK;
    logic           RESET;
    logic [N*W-1:0] IN_DATA;
    logic [N-1:0]   IN_VALID;
    logic [N-1:0]   IN_READY;
    logic           MODE;
    logic [2:0]     SELECT;
    logic [W-1:0]   OUT;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [2:0]     OUT_SEL;
`ifdef STREAM_SELECT_MUX_PARITY_EN
    logic           OUT_PAR;
`endif

    stream_select_mux #(.WIDTH(W), .NUM_IN(N), .SEL_W(3)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .MODE      (MODE),
        .SELECT    (SELECT),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_SEL   (OUT_SEL)
`ifdef STREAM_SELECT_MUX_PARITY_EN
        ,
        .OUT_PAR   (OUT_PAR)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    int data_arr [N];
    int m_out, m_v, m_sel, m_ptr;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic pack();
        for (int k = 0; k < N; k++) IN_DATA[k*W +: W] = data_arr[k][W-1:0];
    endtask

    // returns grant index or -1
    function automatic int model_grant();
        if (MODE == 1'b0) begin
            if (int'(SELECT) < N && IN_VALID[SELECT]) return int'(SELECT);
            return -1;
        end
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (IN_VALID[k]) return k;
        end
        return -1;
    endfunction

    function automatic int model_ready();
        int g;
        g = model_grant();
        if (RESET || g < 0 || !(m_v == 0 || OUT_READY)) return 0;
        return 1 << g;
    endfunction

    task automatic model_reset();
        m_out = 0; m_v = 0; m_sel = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        int g;
        g = model_grant();
        if (m_v == 0 || OUT_READY) begin
            if (g >= 0) begin
                m_out = data_arr[g] & 'hFF;
                m_sel = g;
                m_v   = 1;
                if (MODE) m_ptr = (g + 1) % N;
            end else begin
                m_v = 0;
            end
        end
    endtask

    task automatic compare_outputs(input string tag);
        chk({tag, ".OUT"}, int'(OUT), m_out);
        chk({tag, ".OUT_VALID"}, int'(OUT_VALID), m_v);
        chk({tag, ".OUT_SEL"}, int'(OUT_SEL), m_sel);
`ifdef STREAM_SELECT_MUX_PARITY_EN
        chk({tag, ".OUT_PAR"}, int'(OUT_PAR), int'(^m_out[7:0]));
`endif
    endtask

    // inputs are set at the negedge before calling
    task automatic cycle(input string tag);
        pack();
        #1;
        chk({tag, ".IN_READY"}, int'(IN_READY), model_ready());
        @(posedge CLK);
        model_step();
        #1;
        compare_outputs(tag);
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1; MODE = 1'b0; SELECT = 3'd0; OUT_READY = 1'b1;
        IN_VALID = 8'hFF;
        for (int k = 0; k < N; k++) data_arr[k] = 'h10 + k;
        pack();
        model_reset();
        #2;
        chk("reset.OUT", int'(OUT), 0);
        chk("reset.OUT_VALID", int'(OUT_VALID), 0);
        chk("reset.OUT_SEL", int'(OUT_SEL), 0);
        chk("reset.IN_READY", int'(IN_READY), 0);
        @(negedge CLK);
        RESET = 1'b0;

        // fixed select of channel 5
        SELECT = 3'd5;
        for (int c = 0; c < 3; c++) begin
            pack();
            #1 chk("fixed.IN_READY_lit", int'(IN_READY), 'h20);
            cycle("fixed");
            chk("fixed.OUT_lit", int'(OUT), 'h15);
            chk("fixed.OUT_SEL_lit", int'(OUT_SEL), 5);
        end

        // round-robin fairness from pointer 0
        MODE = 1'b1; IN_VALID = 8'b1000_1001;
        begin
            int exp_seq [6] = '{0, 3, 7, 0, 3, 7};
            for (int c = 0; c < 6; c++) begin
                cycle("rr");
                chk("rr.OUT_SEL_lit", int'(OUT_SEL), exp_seq[c]);
            end
        end

        // move pointer to 7 via a grant on channel 6, then check wrap
        IN_VALID = 8'h40;
        cycle("rr_prep");
        chk("rr_prep.OUT_SEL_lit", int'(OUT_SEL), 6);
        IN_VALID = 8'h81;
        begin
            int exp_w [3] = '{7, 0, 7};
            for (int c = 0; c < 3; c++) begin
                cycle("wrap");
                chk("wrap.OUT_SEL_lit", int'(OUT_SEL), exp_w[c]);
            end
        end

        // back-pressure while SELECT wanders
        MODE = 1'b0; SELECT = 3'd2; IN_VALID = 8'hFF; data_arr[2] = 'h5A;
        cycle("bp_load");
        chk("bp_load.OUT_lit", int'(OUT), 'h5A);
        OUT_READY = 1'b0;
        for (int c = 0; c < 4; c++) begin
            SELECT = 3'(c + 3);
            pack();
            #1 chk("bp.IN_READY_lit", int'(IN_READY), 0);
            cycle("bp");
            chk("bp.OUT_hold_lit", int'(OUT), 'h5A);
            chk("bp.OUT_SEL_hold_lit", int'(OUT_SEL), 2);
        end
        OUT_READY = 1'b1; SELECT = 3'd4;
        cycle("bp_release");
        chk("bp_release.OUT_SEL_lit", int'(OUT_SEL), 4);
        chk("bp_release.OUT_lit", int'(OUT), 'h14);

`ifdef STREAM_SELECT_MUX_PARITY_EN
        SELECT = 3'd5; data_arr[5] = 'hA5;
        cycle("par0");
        chk("par0.OUT_PAR_lit", int'(OUT_PAR), 0);
        data_arr[5] = 'hA4;
        cycle("par1");
        chk("par1.OUT_PAR_lit", int'(OUT_PAR), 1);
`endif

        // no grant in fixed mode clears OUT_VALID but holds data
        IN_VALID = 8'h00;
        cycle("nogrant");
        chk("nogrant.OUT_VALID_lit", int'(OUT_VALID), 0);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            MODE      = 1'($urandom_range(0, 1));
            SELECT    = 3'($urandom_range(0, 7));
            IN_VALID  = 8'($urandom);
            OUT_READY = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) data_arr[k] = $urandom_range(0, 255);
            cycle("rand");
        end

        // reset asserted mid-cycle with a word held
        MODE = 1'b0; SELECT = 3'd1; IN_VALID = 8'hFF; OUT_READY = 1'b0;
        data_arr[1] = 'h77;
        cycle("pre_rst");
        if (OUT_VALID !== 1'b1) cycle("pre_rst2");
        chk("pre_rst.OUT_VALID_lit", int'(OUT_VALID), 1);
        @(posedge CLK);
        model_step();
        #2 RESET = 1'b1;
        model_reset();
        #1;
        chk("midrst.OUT", int'(OUT), 0);
        chk("midrst.OUT_VALID", int'(OUT_VALID), 0);
        chk("midrst.OUT_SEL", int'(OUT_SEL), 0);
        chk("midrst.IN_READY", int'(IN_READY), 0);
        @(negedge CLK);
        RESET = 1'b0; OUT_READY = 1'b1;
        cycle("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
